// File: rtl/booth_datapath.sv
// booth_datapath: register/ALU datapath for a radix-2 Booth multiplier.
// It holds the A (accumulator), Q (multiplier), Q-1 and M (multiplicand)
// registers, the add/subtract ALU and the iteration counter. The sequencing
// controller drives it one register command per cycle.
//
// Optional feature macro: BOOTH_DATAPATH_PRODREG_EN
//   defined   -> product is a separate register. It captures {A, Q} when
//                countin first rises.
//   undefined -> product is the live concatenation {A[WIDTH-1:0], Q}.
module booth_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 q1,
    input  logic                 q2,
    input  logic                 a1,
    input  logic                 a2,
    input  logic                 m1,
    input  logic                 alu,
    input  logic                 count,
    output logic                 c1,
    output logic                 c2,
    output logic                 countin,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // A and M carry one guard bit, so even M = -2^(WIDTH-1) cannot overflow the ALU.
    logic [WIDTH:0]   a_reg, a_next;
    logic [WIDTH:0]   m_reg, m_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             qm1_reg, qm1_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH:0]   alu_result;
    logic [WIDTH:0]   m_sext;

    // Build the sign-extended multiplicand bit by bit. The guard bit repeats the sign.
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_m_sext
            if (gi < WIDTH) begin : g_low
                assign m_sext[gi] = multiplicand[gi];
            end else begin : g_guard
                assign m_sext[gi] = multiplicand[WIDTH-1];
            end
        end
    endgenerate

    // Add or subtract, using only the current registered A and M.
    always_comb begin
        alu_result = alu ? (a_reg - m_reg) : (a_reg + m_reg);
    end

    // Decode the per-register commands into next-state values.
    always_comb begin
        a_next   = a_reg;
        m_next   = m_reg;
        q_next   = q_reg;
        qm1_next = qm1_reg;
        cnt_next = cnt_reg;

        case ({a1, a2})
            2'b01:   a_next = alu_result;
            2'b10:   a_next = {a_reg[WIDTH], a_reg[WIDTH:1]};
            2'b11:   a_next = '0;
            default: a_next = a_reg;
        endcase

        if (m1) begin
            m_next = m_sext;
        end

        case ({q1, q2})
            2'b01: begin
                q_next   = multiplier;
                qm1_next = 1'b0;
            end
            2'b10: begin
                // Use the pre-edge A[0], even if A is also being updated this cycle.
                q_next   = {a_reg[0], q_reg[WIDTH-1:1]};
                qm1_next = q_reg[0];
            end
            default: begin
                q_next   = q_reg;
                qm1_next = qm1_reg;
            end
        endcase

        // A Q load restarts the iteration count and takes precedence over count.
        if ({q1, q2} == 2'b01) begin
            cnt_next = '0;
        end else if (count && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // State registers. Reset takes priority over every command.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            qm1_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            a_reg   <= a_next;
            m_reg   <= m_next;
            q_reg   <= q_next;
            qm1_reg <= qm1_next;
            cnt_reg <= cnt_next;
        end
    end

    assign c1      = q_reg[0];
    assign c2      = qm1_reg;
    assign countin = (cnt_reg == CNT_MAX);

`ifdef BOOTH_DATAPATH_PRODREG_EN
    logic [2*WIDTH-1:0] prod_reg;
    logic               prod_capture;

    // Capture on the edge where the counter first reaches WIDTH.
    // This makes the new product appear in the same cycle that countin goes high.
    assign prod_capture = (cnt_next == CNT_MAX) && (cnt_reg != CNT_MAX);

    // Hold the last completed product across the following multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_reg <= '0;
        end else if (prod_capture) begin
            prod_reg <= {a_next[WIDTH-1:0], q_next};
        end
    end

    assign product = prod_reg;
`else
    assign product = {a_reg[WIDTH-1:0], q_reg};
`endif

endmodule

// File: tb/tb_booth_datapath.sv
// tb_booth_datapath: directed and random Booth multiplies for WIDTH=8.
// The bench acts as the controller. Expected products come from plain
// signed multiplication. Expected Booth pairs come from the multiplier bits.
module tb_booth_datapath;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   multiplicand, multiplier;
    logic           q1, q2, a1, a2, m1, alu, count;
    logic           c1, c2, countin;
    logic [2*W-1:0] product;

    int passed = 0;
    int total  = 0;
    logic [2*W-1:0] prev_prod = '0;

    booth_datapath #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .q1(q1), .q2(q2), .a1(a1), .a2(a2), .m1(m1), .alu(alu), .count(count),
        .c1(c1), .c2(c2), .countin(countin), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic cmd(input logic [1:0] qc, input logic [1:0] ac, input logic mc,
                       input logic op, input logic cnt);
        {q1, q2} = qc;
        {a1, a2} = ac;
        m1       = mc;
        alu      = op;
        count    = cnt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One controller-style multiply. If abort_at >= 0, reset is asserted
    // at the start of that iteration.
    task automatic mult(input logic [W-1:0] mc, input logic [W-1:0] mp, input int abort_at);
        int          ia, ib, p;
        logic [15:0] expp;
        logic        prev_bit;
        ia = int'($signed(mc));
        ib = int'($signed(mp));
        p  = ia * ib;
        expp = p[15:0];
        multiplicand = mc;
        multiplier   = mp;
        cmd(2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
        step();
        chk("load_countin", 32'(countin), 32'd0);
`ifdef BOOTH_DATAPATH_PRODREG_EN
        chk("prod_hold_load", 32'(product), 32'(prev_prod));
`endif
        for (int i = 0; i < W; i++) begin
            if (i == abort_at) begin
                cmd(2'b01, 2'b01, 1'b1, 1'b1, 1'b1);
                reset = 1'b1;
                step();
                reset = 1'b0;
                cmd(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
                chk("abort_c1", 32'(c1), 32'd0);
                chk("abort_c2", 32'(c2), 32'd0);
                chk("abort_countin", 32'(countin), 32'd0);
                chk("abort_product", 32'(product), 32'd0);
                prev_prod = '0;
                $display("mult %0d x %0d aborted by reset at iteration %0d", ia, ib, i);
                return;
            end
            prev_bit = (i == 0) ? 1'b0 : mp[i-1];
            chk($sformatf("pair_c1_%0d", i), 32'(c1), 32'(mp[i]));
            chk($sformatf("pair_c2_%0d", i), 32'(c2), 32'(prev_bit));
            if (mp[i] != prev_bit) begin
                // 10 -> subtract M, 01 -> add M
                cmd(2'b00, 2'b01, 1'b0, mp[i], 1'b0);
                step();
            end
            cmd(2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
            step();
            chk($sformatf("countin_it%0d", i), 32'(countin), 32'(i == W - 1));
`ifdef BOOTH_DATAPATH_PRODREG_EN
            if (i != W - 1) chk("prod_hold_iter", 32'(product), 32'(prev_prod));
`endif
        end
        cmd(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("product", 32'(product), 32'(expp));
        step();
        chk("product_hold", 32'(product), 32'(expp));
        chk("countin_hold", 32'(countin), 32'd1);
        prev_prod = expp;
        $display("mult %0d x %0d -> product %04h (expected %04h)", ia, ib, product, expp);
    endtask

    initial begin
        reset = 1'b1;
        multiplicand = '0;
        multiplier   = '0;
        cmd(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_c1", 32'(c1), 32'd0);
        chk("rst_c2", 32'(c2), 32'd0);
        chk("rst_countin", 32'(countin), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        $display("reset checked");
        reset = 1'b0;

        mult(8'd3, 8'd5, -1);
        mult(8'hFE, 8'd9, -1);
        mult(8'hFD, 8'd7, -1);
        mult(8'h80, 8'h80, -1);
        mult(8'd127, 8'h80, -1);
        mult(8'd0, 8'hFF, -1);
        mult(8'hFF, 8'd0, -1);
        for (int r = 0; r < 20; r++) begin
            mult(8'($urandom), 8'($urandom), -1);
        end

        // Keep count high for 12 cycles after a Q load with no shifts.
        multiplier = 8'h5A;
        cmd(2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
        step();
        cmd(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("sat_countin_%0d", k), 32'(countin), 32'(k >= W - 1));
        end
        prev_prod = {8'h00, 8'h5A};
`ifdef BOOTH_DATAPATH_PRODREG_EN
        chk("sat_product", 32'(product), 32'(prev_prod));
`endif
        cmd(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        chk("load_beats_count", 32'(countin), 32'd0);
        cmd(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("saturation and load-over-count checked");

        mult(8'd11, 8'hF3, 4);
        mult(8'd6, 8'hFA, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
